// File: rtl/game_pkg.sv
// Shared types for the direction input path: direction codes, repeat FSM
// states and the fixed-priority press encoder.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Button vectors are ordered {l,r,d,u}, so the bit index equals the dir_t
    // code; same-cycle presses resolve left > right > down > up.
    function automatic dir_t prio_dir(input logic [3:0] rise);
        dir_t d;
        d = DIR_UP;
        if (rise[3])      d = DIR_LEFT;
        else if (rise[2]) d = DIR_RIGHT;
        else if (rise[1]) d = DIR_DOWN;
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stable-level debounce counter and a
// press pulse that is high in the first cycle the debounced level reads 1.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 650_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out
);

    localparam int unsigned CW = $clog2(DB_CYCLES) + 1;

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; accept the new level after DB_CYCLES.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise_d   = sync2_q;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign level_out = stable_q;
    assign rise_out  = rise_q;

endmodule

// File: rtl/dir_input_ctrl.sv
// Turns four raw buttons into direction commands: debounce, priority encode
// of press events, optional auto-repeat of the held direction, and a single
// pending command exposed through a valid/ready handshake.
//
// Handshake: cmd_valid stays high and cmd_dir holds steady until a cycle with
// cmd_valid & cmd_ready (the transfer). A new event while a command is pending
// and not being transferred replaces it and pulses cmd_overrun; an event in
// the transfer cycle simply loads behind it. cmd_ready without cmd_valid has
// no effect.
module dir_input_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 650_000,
    parameter int unsigned REPEAT_DELAY  = 26_000_000,
    parameter int unsigned REPEAT_PERIOD = 9_750_000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnu,
    input  logic       btnd,
    input  logic       btnr,
    input  logic       btnl,
    output logic [1:0] cmd_dir,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_overrun,
    output logic [3:0] btn_level
);

    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    logic [3:0] raw_vec, level_vec, rise_vec;

    rep_state_t    state_q, state_d;
    dir_t          held_q, held_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [TW-1:0] tmr_limit;
    logic          emit;
    dir_t          emit_dir;
    logic          press;
    dir_t          press_dir;

    logic          valid_q, valid_d;
    dir_t          dir_q, dir_d;
    logic          ovr_q, ovr_d;

    assign raw_vec = {btnl, btnr, btnd, btnu};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_in    (raw_vec[i]),
            .level_out (level_vec[i]),
            .rise_out  (rise_vec[i])
        );
    end

    assign press     = |rise_vec;
    assign press_dir = prio_dir(rise_vec);
    assign tmr_limit = (state_q == DELAY) ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1);

    // Repeat FSM: a press always wins; otherwise track the held button and its timer.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        tmr_d    = tmr_q;
        emit     = 1'b0;
        emit_dir = held_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    emit     = 1'b1;
                    emit_dir = press_dir;
                    held_d   = press_dir;
                    tmr_d    = '0;
                    if (REPEAT_EN) state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (press) begin
                    emit     = 1'b1;
                    emit_dir = press_dir;
                    held_d   = press_dir;
                    tmr_d    = '0;
                    state_d  = DELAY;
                end else if (!level_vec[held_q]) begin
                    state_d = IDLE;
                end else if (tmr_q == tmr_limit) begin
                    emit    = 1'b1;
                    tmr_d   = '0;
                    state_d = REPEAT;
                end else if (tmr_q != '1) begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Repeat FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            held_q  <= DIR_UP;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            tmr_q   <= tmr_d;
        end
    end

    // One-entry command buffer: load on event, clear on transfer, flag replacement.
    always_comb begin
        valid_d = valid_q & ~cmd_ready;
        dir_d   = dir_q;
        ovr_d   = 1'b0;
        if (emit) begin
            valid_d = 1'b1;
            dir_d   = emit_dir;
            ovr_d   = valid_q & ~cmd_ready;
        end
    end

    // Command buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dir_q   <= DIR_UP;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd_dir     = dir_q;
    assign cmd_valid   = valid_q;
    assign cmd_overrun = ovr_q;
    assign btn_level   = level_vec;

endmodule
